// File: rtl/gcd_operand_fifo_if.sv
// Operand-pair handshake bundle between the upstream producer, the operand FIFO
// and the gcd_coprocessor operand port.
interface gcd_operand_fifo_if #(
  parameter int W = 16
);
  logic         in_val;
  logic [W-1:0] in_bits_A;
  logic [W-1:0] in_bits_B;
  logic         in_rdy;
  logic         out_val;
  logic [W-1:0] out_bits_A;
  logic [W-1:0] out_bits_B;
  logic         out_rdy;

  // FIFO side: accepts pairs from upstream, presents pairs to the coprocessor
  modport slave (
    input  in_val, in_bits_A, in_bits_B, out_rdy,
    output in_rdy, out_val, out_bits_A, out_bits_B
  );

  // Producer/consumer side
  modport master (
    output in_val, in_bits_A, in_bits_B, out_rdy,
    input  in_rdy, out_val, out_bits_A, out_bits_B
  );
endinterface

// File: rtl/gcd_operand_fifo.sv
// Operand-pair FIFO feeding the gcd_coprocessor, with a saturating stall counter.
// Define GCD_OPQ_BYPASS_EN to let an incoming pair pass straight through an empty FIFO.
module gcd_operand_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  gcd_operand_fifo_if.slave      q,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            stall_cycles
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_a [DEPTH];
  logic [W-1:0]  mem_b [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          empty;
  logic          full;
  logic          show_in;
  logic          take_in;
  logic          enq;
  logic          deq;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

`ifdef GCD_OPQ_BYPASS_EN
  // An empty FIFO shows the incoming pair directly; it is only stored if not taken now
  assign show_in = empty && q.in_val && reset;
`else
  assign show_in = 1'b0;
`endif
  assign take_in = show_in && q.out_rdy;

  assign q.in_rdy = reset && !full;
  assign enq      = q.in_val && q.in_rdy && !take_in;
  assign deq      = !empty && q.out_rdy;

  always_comb begin
    q.out_val    = !empty || show_in;
    q.out_bits_A = mem_a[head];
    q.out_bits_B = mem_b[head];
    if (show_in) begin
      q.out_bits_A = q.in_bits_A;
      q.out_bits_B = q.in_bits_B;
    end
  end

  // Control state: pointers, occupancy and stall counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      stall_cycles <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (q.out_val && !q.out_rdy) stall_cycles <= sat_inc16(stall_cycles);
    end
  end

  // Storage is written on enqueue only and never reset
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_a[tail] <= q.in_bits_A;
      mem_b[tail] <= q.in_bits_B;
    end
  end
endmodule

// File: doc/gcd_operand_fifo.md
GCD_OPERAND_FIFO -- requirements
Module: gcd_operand_fifo

Interface
REQ-001 Parameter W, default 16, operand bit width; SHALL match the downstream gcd_coprocessor operand width.
REQ-002 Parameter DEPTH, default 4, number of operand-pair entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_val  input  1  upstream offers an operand pair.
REQ-006 in_bits_A  input  W  operand A from upstream.
REQ-007 in_bits_B  input  W  operand B from upstream.
REQ-008 in_rdy  output  1  FIFO can accept a pair this cycle.
REQ-009 out_val  output  1  pair available to the coprocessor (drives operands_val).
REQ-010 out_bits_A  output  W  head operand A (drives operands_bits_A).
REQ-011 out_bits_B  output  W  head operand B (drives operands_bits_B).
REQ-012 out_rdy  input  1  coprocessor accepts the pair (from operands_rdy).
REQ-013 count  output  log2(DEPTH)+1  number of stored entries.
REQ-014 stall_cycles  output  16  saturating count of cycles with out_val=1 and out_rdy=0.

Function
REQ-015 Enqueue SHALL occur on a rising edge when in_val=1 and in_rdy=1; A and B SHALL be written as one entry at the tail.
REQ-016 Dequeue SHALL occur on a rising edge when out_val=1 and out_rdy=1; the head entry SHALL be removed.
REQ-017 in_rdy SHALL be 1 exactly when count<DEPTH and reset=1; when the FIFO is full, in_rdy SHALL be 0 even if a dequeue happens in the same cycle.
REQ-018 out_val SHALL be 1 when count!=0; out_bits_A/B SHALL present the head entry; when out_val=0, out_bits_A/B are don't-care.
REQ-019 When an enqueue and a dequeue happen in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-020 Head and tail pointers SHALL wrap modulo DEPTH; data order SHALL be strictly FIFO across wrap.
REQ-021 Without bypass, an enqueued pair SHALL appear on out_val no earlier than the next cycle (1-cycle latency).
REQ-022 stall_cycles SHALL increment by 1 each cycle with out_val=1 and out_rdy=0, and SHALL hold at 16'hFFFF once reached.
REQ-023 Entries SHALL be passed unmodified; no arithmetic is applied to operand values, including zero operands.

Reset
REQ-024 While reset=0 at a rising edge, head, tail, count and stall_cycles SHALL clear to 0.
REQ-025 After reset, out_val SHALL be 0 and in_rdy SHALL be 1; storage contents need not be cleared.
REQ-026 Reset asserted mid-operation SHALL discard all stored pairs; no pair SHALL be emitted afterwards unless it is re-enqueued.

Configuration
REQ-027 Macro GCD_OPQ_BYPASS_EN, when defined, SHALL enable the empty-bypass path; when undefined, REQ-021 latency holds unconditionally.
REQ-028 With GCD_OPQ_BYPASS_EN defined, count=0, in_val=1 and out_rdy=1: out_val SHALL be 1 combinationally, out_bits SHALL equal in_bits, the pair SHALL be consumed that cycle, and count SHALL stay 0.
REQ-029 With GCD_OPQ_BYPASS_EN defined, count=0, in_val=1 and out_rdy=0: the pair SHALL be enqueued normally; out_val SHALL still be 1 that cycle, showing the in_bits.

Verification
REQ-030 Macro undefined, push (27,15) with out_rdy=1 -> out_val=1 the next cycle with out_bits=(27,15); count returns to 0 after the pop.
REQ-031 out_rdy=0, push (21,49),(25,30),(19,27),(40,40), then offer (250,190) -> count=4, in_rdy=0, fifth pair not accepted; stall_cycles increments every cycle.
REQ-032 Full FIFO, out_rdy=1 with in_val=1 -> pop (21,49), no push that cycle; the next cycle pushes (250,190); output order is 21,25,19,40,250.
REQ-033 Push and pop 6 pairs, (0,0) through (6993,999), at DEPTH=4 -> all pointers wrap; outputs appear in exact input order; (0,0) is passed intact.
REQ-034 Hold reset=0 for one edge with count=3 -> count=0, out_val=0, stall_cycles=0, and the stored pairs are never emitted.
REQ-035 Macro defined, empty FIFO, out_rdy=1, push (96,4096) -> out_val=1 and out_bits=(96,4096) in the same cycle; count stays 0.
